// File: rtl/instr_decode_stage_pkg.sv
// Shared decode-stage types: op and immediate-select encodings, buffer states,
// and the decoded-field record. The immediate extender imports this as well.
package instr_decode_stage_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IMM_DP  = 2'd0,
    IMM_MEM = 2'd1,
    IMM_BR  = 2'd2,
    IMM_ILL = 2'd3
  } imm_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]  cond;
    logic [23:0] immediate;
    logic [3:0]  rd;
    imm_src_e    imm_src;
    logic        use_imm;
    logic        illegal;
  } dec_t;

  localparam dec_t DEC_ZERO = dec_t'('0);

endpackage

// File: rtl/instr_decode_if.sv
// Fetch-side and execute-side handshake plus decoded fields of the decode stage.
interface instr_decode_if #(
  parameter int PC_W = 32
) ();
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [PC_W-1:0] if_pc;
  logic            if_ready;
  logic            flush;
  logic            id_ready;
  logic            id_valid;
  logic [23:0]     immediate;
  logic [1:0]      imm_src;
  logic            use_imm;
  logic [3:0]      cond;
  logic [3:0]      rd;
  logic [PC_W-1:0] id_pc;
  logic            illegal;

  modport master (
    output if_valid, if_instr, if_pc, flush, id_ready,
    input  if_ready, id_valid, immediate, imm_src, use_imm, cond, rd, id_pc, illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, id_ready,
    output if_ready, id_valid, immediate, imm_src, use_imm, cond, rd, id_pc, illegal
  );
endinterface

// File: rtl/instr_decode_stage_field_decode.sv
// Combinational op-to-extender mapping, applied once to the word entering the buffer.
module instr_field_decode
  import instr_decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);
  op_e  op;
  logic unused_bits;

  assign op          = op_e'(instr[27:26]);
  assign unused_bits = instr[24];

  always_comb begin
    // NOTE: assign a full default first so no branch can leave a field unset and infer a latch.
    dec           = DEC_ZERO;
    dec.cond      = instr[31:28];
    dec.immediate = instr[23:0];
    dec.rd        = instr[15:12];
    unique case (op)
      OP_DP: begin
        dec.imm_src = IMM_DP;
        dec.use_imm = instr[25];
      end
      OP_MEM: begin
        dec.imm_src = IMM_MEM;
        dec.use_imm = ~instr[25];
      end
      OP_BR: begin
        dec.imm_src = IMM_BR;
        dec.use_imm = 1'b1;
      end
      OP_ILL: begin
        dec.imm_src = IMM_ILL;
        dec.illegal = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: two-entry skid buffer holding pre-decoded instructions; all
// outputs come straight from the head-entry registers.
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_decode_if.slave bus
);
  state_e          state;
  logic            if_ready_q;
  logic            id_valid_q;
  dec_t            in_dec;
  dec_t            head_dec;
  dec_t            tail_dec;
  logic [PC_W-1:0] head_pc;
  logic [PC_W-1:0] tail_pc;
  logic            push;
  logic            pop;

  instr_field_decode u_field_decode (
    .instr (bus.if_instr),
    .dec   (in_dec)
  );

  assign push = bus.if_valid & if_ready_q;
  assign pop  = id_valid_q & bus.id_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      if_ready_q <= 1'b1;
      id_valid_q <= 1'b0;
      head_dec   <= DEC_ZERO;
      head_pc    <= '0;
    end else if (bus.flush) begin
      // Head data is left alone so outputs hold while id_valid is low.
      state      <= ST_EMPTY;
      if_ready_q <= 1'b1;
      id_valid_q <= 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (push) begin
            head_dec   <= in_dec;
            head_pc    <= bus.if_pc;
            state      <= ST_ONE;
            id_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_dec <= in_dec;
            head_pc  <= bus.if_pc;
          end else if (push) begin
            state      <= ST_TWO;
            if_ready_q <= 1'b0;
          end else if (pop) begin
            state      <= ST_EMPTY;
            id_valid_q <= 1'b0;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_dec   <= tail_dec;
            head_pc    <= tail_pc;
            state      <= ST_ONE;
            if_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          if_ready_q <= 1'b1;
          id_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the tail slot is pure storage and is never read before being written, so it has no reset.
  always_ff @(posedge clk) begin
    if (state == ST_ONE && push && !pop) begin
      tail_dec <= in_dec;
      tail_pc  <= bus.if_pc;
    end
  end

  assign bus.if_ready  = if_ready_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.immediate = head_dec.immediate;
  assign bus.imm_src   = head_dec.imm_src;
  assign bus.use_imm   = head_dec.use_imm;
  assign bus.cond      = head_dec.cond;
  assign bus.rd        = head_dec.rd;
  assign bus.id_pc     = head_pc;
  assign bus.illegal   = head_dec.illegal;
endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameter: PC_W, 32, width of the program-counter field carried alongside each instruction.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 if_valid  input  1  fetch presents an instruction.
REQ-005 if_instr  input  32  fetched instruction word.
REQ-006 if_pc  input  PC_W  address of if_instr.
REQ-007 if_ready  output  1  stage accepts the word this cycle; registered, never combinational from id_ready.
REQ-008 flush  input  1  discard all held instructions (branch taken).
REQ-009 id_ready  input  1  immediate/execute stage accepts the word this cycle.
REQ-010 id_valid  output  1  decoded fields below are valid.
REQ-011 immediate  output  24  instr[23:0] of the head entry, feeding the immediate extender.
REQ-012 imm_src  output  2  extender select: 0 data-processing rotate, 1 memory offset, 2 branch.
REQ-013 use_imm  output  1  operand 2 comes from the extender.
REQ-014 cond  output  4  instr[31:28] of the head entry.
REQ-015 rd  output  4  instr[15:12] of the head entry.
REQ-016 id_pc  output  PC_W  PC of the head entry.
REQ-017 illegal  output  1  head entry has op = 2'b11.

Function
REQ-018 A word transfers in when if_valid && if_ready, and out when id_valid && id_ready.
REQ-019 Storage is a 2-entry skid buffer with states EMPTY, ONE and TWO; id_valid = (state != EMPTY); if_ready = (state != TWO).
REQ-020 EMPTY goes to ONE on input-only; ONE goes to TWO on input-only, to EMPTY on output-only, and stays ONE when input and output coincide; TWO goes to ONE on output.
REQ-021 If there is input in TWO, the stage SHALL ignore it, since if_ready = 0.
REQ-022 Outputs SHALL always reflect the oldest entry; order is FIFO.
REQ-023 Latency: an accepted word appears on the outputs the next cycle; throughput is 1 word per cycle with id_ready held high.
REQ-024 Decode from op = instr[27:26]: 00 gives imm_src 0 with use_imm = instr[25]; 01 gives imm_src 1 with use_imm = ~instr[25]; 10 gives imm_src 2 with use_imm 1; 11 gives imm_src 3, use_imm 0 and illegal 1.
REQ-025 Decode SHALL be registered on entry into the buffer, with no combinational decode path on the outputs.
REQ-026 flush SHALL force EMPTY next cycle, dropping any same-cycle input and ignoring id_ready; flush has priority over all transfers.
REQ-027 When id_valid = 0, the decoded outputs SHALL hold their last value; consumers qualify them with id_valid.
REQ-028 Illegal words SHALL flow through like legal ones; the stage does not stall on them.

Reset
REQ-029 While rst_n = 0 the stage SHALL asynchronously force state EMPTY, id_valid 0, if_ready 1, every data output 0 and imm_src 0.
REQ-030 Words held at reset assertion SHALL be discarded; after deassertion the first accepted word SHALL appear one cycle later.

Structure
REQ-031 Op encodings, imm_src codes (0 DP, 1 MEM, 2 BR, 3 ILL) and the state encoding SHALL live in the shared package, which the immediate extender also uses.
REQ-032 A single sub-module, instr_field_decode, SHALL hold the combinational op-to-imm_src/use_imm/illegal mapping, instantiated once at the buffer input.

Verification
REQ-033 0xE3A000FF in with id_ready = 1 -> next cycle id_valid 1, imm_src 0, use_imm 1, immediate 0xA000FF, rd 0, cond 0xE.
REQ-034 0xE5910008 then 0xEA000004 back-to-back -> outputs (1, 0x910008, use_imm 1) then (2, 0x000004, use_imm 1), in order, one per cycle.
REQ-035 id_ready = 0 while 3 words are offered -> if_ready drops after 2 accepts; on release, 3 words emerge in order with none lost or duplicated.
REQ-036 flush in state TWO together with if_valid -> next cycle id_valid 0, if_ready 1, and the flushed word never appears.
REQ-037 0xFC000000 -> illegal 1, imm_src 3, use_imm 0, and the following legal word is delivered normally.
REQ-038 rst_n low mid-stream in TWO -> id_valid 0 immediately with no clock edge; no stale words after release.
